// File: rtl/comp_arbiter.sv
// comp_arbiter: shares one external comparator between two execute-stage
// requesters (req0 = branch unit, req1 = ALU SLT path).
// A granted request has its operands registered; the comparator is driven only
// from those registers, and the 1-bit result returns over a valid/ready handshake.
//
// Build option:
//   COMP_ARB_RR_EN  defined   -> round-robin tie-break (last_gnt tracked)
//   COMP_ARB_RR_EN  undefined -> fixed priority, req0 always wins a tie
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no op in flight, grant logic active, req_ready_o may assert
// EVAL  | operands registered and driving the comparator, result sampled
// RESP  | response presented to owner, held until rsp_ready_i[owner]
module comp_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid_i,
    output logic [1:0]      req_ready_o,
    input  logic [XLEN-1:0] req0_rs1_i,
    input  logic [XLEN-1:0] req0_rs2_i,
    input  logic [2:0]      req0_funct3_i,
    input  logic [XLEN-1:0] req1_rs1_i,
    input  logic [XLEN-1:0] req1_rs2_i,
    input  logic [2:0]      req1_funct3_i,
    output logic [XLEN-1:0] cmp_rs1_o,
    output logic [XLEN-1:0] cmp_rs2_o,
    output logic [2:0]      cmp_funct3_o,
    input  logic            cmp_result_i,
    output logic [1:0]      rsp_valid_o,
    input  logic [1:0]      rsp_ready_i,
    output logic            rsp_result_o,
    output logic            rsp_err_o,
    output logic            busy_o
);

    localparam logic [2:0] FUNCT3_ILLEGAL = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e          state_q,  state_d;
    logic [XLEN-1:0] rs1_q,    rs1_d;
    logic [XLEN-1:0] rs2_q,    rs2_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            owner_q,  owner_d;
    logic            result_q, result_d;
    logic            err_q,    err_d;

    logic [1:0]      gnt;
    logic            gnt_idx;
    logic            accept;

`ifdef COMP_ARB_RR_EN
    logic            last_gnt_q, last_gnt_d;
`endif

    // Grant selection; only meaningful while idle, combinational from req_valid_i
    always_comb begin
        gnt = 2'b00;
        if (state_q == ST_IDLE) begin
            case (req_valid_i)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
`ifdef COMP_ARB_RR_EN
                2'b11:   gnt = last_gnt_q ? 2'b01 : 2'b10;
`else
                2'b11:   gnt = 2'b01;
`endif
                default: gnt = 2'b00;
            endcase
        end
        gnt_idx = gnt[1];
        accept  = |(gnt & req_valid_i);
    end

    // Next-state logic: operand latch on accept, result capture in EVAL, handshake in RESP
    always_comb begin
        state_d  = state_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        funct3_d = funct3_q;
        owner_d  = owner_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_EVAL;
                    owner_d = gnt_idx;
                    if (gnt_idx) begin
                        rs1_d    = req1_rs1_i;
                        rs2_d    = req1_rs2_i;
                        funct3_d = req1_funct3_i;
                    end else begin
                        rs1_d    = req0_rs1_i;
                        rs2_d    = req0_rs2_i;
                        funct3_d = req0_funct3_i;
                    end
                end
            end
            ST_EVAL: begin
                state_d = ST_RESP;
                // Illegal op: comparator output is ignored and the result forced low
                if (funct3_q == FUNCT3_ILLEGAL) begin
                    result_d = 1'b0;
                    err_d    = 1'b1;
                end else begin
                    result_d = cmp_result_i;
                    err_d    = 1'b0;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef COMP_ARB_RR_EN
    // Tie-break memory moves only when a request is actually taken
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (accept) begin
            last_gnt_d = gnt_idx;
        end
    end

    // Tie-break register; resets to 1 so req0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`endif

    // State and datapath registers; reset drops any op in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rs1_q    <= '0;
            rs2_q    <= '0;
            funct3_q <= 3'b000;
            owner_q  <= 1'b0;
            result_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            funct3_q <= funct3_d;
            owner_q  <= owner_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Outputs: comparator fed from registers only, response gated to RESP
    always_comb begin
        req_ready_o  = gnt;
        cmp_rs1_o    = rs1_q;
        cmp_rs2_o    = rs2_q;
        cmp_funct3_o = funct3_q;
        rsp_valid_o  = 2'b00;
        rsp_result_o = 1'b0;
        rsp_err_o    = 1'b0;
        if (state_q == ST_RESP) begin
            rsp_valid_o  = owner_q ? 2'b10 : 2'b01;
            rsp_result_o = result_q;
            rsp_err_o    = err_q;
        end
        busy_o = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_comp_arbiter.sv
// Directed bench for comp_arbiter; inputs driven and outputs sampled around
// the falling clock edge. An external comparator model sits on the cmp_* bus.
module tb_comp_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      req_valid_i = 2'b00;
    logic [1:0]      req_ready_o;
    logic [XLEN-1:0] req0_rs1_i = '0;
    logic [XLEN-1:0] req0_rs2_i = '0;
    logic [2:0]      req0_funct3_i = 3'b000;
    logic [XLEN-1:0] req1_rs1_i = '0;
    logic [XLEN-1:0] req1_rs2_i = '0;
    logic [2:0]      req1_funct3_i = 3'b000;
    logic [XLEN-1:0] cmp_rs1_o;
    logic [XLEN-1:0] cmp_rs2_o;
    logic [2:0]      cmp_funct3_o;
    logic            cmp_result_i;
    logic [1:0]      rsp_valid_o;
    logic [1:0]      rsp_ready_i = 2'b00;
    logic            rsp_result_o;
    logic            rsp_err_o;
    logic            busy_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    comp_arbiter #(.XLEN(XLEN)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req0_rs1_i    (req0_rs1_i),
        .req0_rs2_i    (req0_rs2_i),
        .req0_funct3_i (req0_funct3_i),
        .req1_rs1_i    (req1_rs1_i),
        .req1_rs2_i    (req1_rs2_i),
        .req1_funct3_i (req1_funct3_i),
        .cmp_rs1_o     (cmp_rs1_o),
        .cmp_rs2_o     (cmp_rs2_o),
        .cmp_funct3_o  (cmp_funct3_o),
        .cmp_result_i  (cmp_result_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_result_o  (rsp_result_o),
        .rsp_err_o     (rsp_err_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    // External comparator; returns 1 for the illegal op so forcing is visible
    always_comb begin
        case (cmp_funct3_o)
            3'b000:  cmp_result_i = (cmp_rs1_o == cmp_rs2_o);
            3'b001:  cmp_result_i = (cmp_rs1_o != cmp_rs2_o);
            3'b010:  cmp_result_i = ($signed(cmp_rs1_o) <  $signed(cmp_rs2_o));
            3'b100:  cmp_result_i = ($signed(cmp_rs1_o) <  $signed(cmp_rs2_o));
            3'b101:  cmp_result_i = ($signed(cmp_rs1_o) >= $signed(cmp_rs2_o));
            3'b110:  cmp_result_i = (cmp_rs1_o <  cmp_rs2_o);
            3'b111:  cmp_result_i = (cmp_rs1_o >= cmp_rs2_o);
            default: cmp_result_i = 1'b1;
        endcase
    end

    // Present a request, wait (bounded) for its accept edge, then drop valid.
    // Returns at the falling edge of the EVAL cycle.
    task automatic issue(input int who, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, output bit acc);
        int n;
        acc = 1'b0;
        n = 0;
        @(negedge clk);
        if (who == 0) begin
            req0_rs1_i = a; req0_rs2_i = b; req0_funct3_i = f;
        end else begin
            req1_rs1_i = a; req1_rs2_i = b; req1_funct3_i = f;
        end
        req_valid_i[who] = 1'b1;
        while (!acc && n < 20) begin
            #1;
            if (req_ready_o[who]) begin
                acc = 1'b1;
                @(posedge clk);
            end else begin
                @(negedge clk);
            end
            n++;
        end
        @(negedge clk);
        req_valid_i[who] = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total_cnt++;
        if ({req_ready_o, rsp_valid_o, rsp_result_o, rsp_err_o, busy_o} !== 7'b0)
            $display("FAIL reset_ctrl: got %b want 0", {req_ready_o, rsp_valid_o, rsp_result_o, rsp_err_o, busy_o});
        else pass_cnt++;
        total_cnt++;
        if ({cmp_rs1_o, cmp_rs2_o, cmp_funct3_o} !== '0)
            $display("FAIL reset_cmp: got %h/%h/%b want 0", cmp_rs1_o, cmp_rs2_o, cmp_funct3_o);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_eval();
        bit acc;
        issue(0, 32'h5, 32'h5, 3'b000, acc);
        total_cnt++;
        if (!acc || busy_o !== 1'b1) $display("FAIL mid_eval_busy: acc %0d busy %b want 1", acc, busy_o);
        else pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({busy_o, rsp_valid_o, req_ready_o, cmp_funct3_o} !== 8'b0 || cmp_rs1_o !== 32'h0)
            $display("FAIL mid_eval_reset: busy %b rsp_v %b rdy %b rs1 %h want all 0", busy_o, rsp_valid_o, req_ready_o, cmp_rs1_o);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (busy_o !== 1'b0) $display("FAIL after_reset_idle: busy %b want 0", busy_o);
        else pass_cnt++;
    endtask

    task automatic test_beq();
        bit acc;
        issue(0, 32'h5, 32'h5, 3'b000, acc);
        total_cnt++;
        if (!acc || rsp_valid_o !== 2'b00 || cmp_rs1_o !== 32'h5 || cmp_rs2_o !== 32'h5)
            $display("FAIL beq_eval: acc %0d rsp_v %b rs1 %h rs2 %h want 1 00 5 5", acc, rsp_valid_o, cmp_rs1_o, cmp_rs2_o);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({rsp_valid_o, rsp_result_o, rsp_err_o} !== 4'b0110)
            $display("FAIL beq_rsp: got %b want 0110", {rsp_valid_o, rsp_result_o, rsp_err_o});
        else pass_cnt++;
        rsp_ready_i = 2'b01;
        @(negedge clk);
        rsp_ready_i = 2'b00;
        total_cnt++;
        if (busy_o !== 1'b0 || rsp_valid_o !== 2'b00)
            $display("FAIL beq_done: busy %b rsp_v %b want 0 00", busy_o, rsp_valid_o);
        else pass_cnt++;
    endtask

    task automatic test_slt_bltu();
        bit acc;
        issue(1, 32'hFFFF_FFFF, 32'h1, 3'b010, acc);
        @(negedge clk);
        total_cnt++;
        if (!acc || {rsp_valid_o, rsp_result_o, rsp_err_o} !== 4'b1010)
            $display("FAIL slt_rsp: acc %0d got %b want 1010", acc, {rsp_valid_o, rsp_result_o, rsp_err_o});
        else pass_cnt++;
        rsp_ready_i = 2'b10;
        @(negedge clk);
        rsp_ready_i = 2'b00;
        issue(0, 32'hFFFF_FFFF, 32'h1, 3'b110, acc);
        @(negedge clk);
        total_cnt++;
        if (!acc || {rsp_valid_o, rsp_result_o, rsp_err_o} !== 4'b0100)
            $display("FAIL bltu_rsp: acc %0d got %b want 0100", acc, {rsp_valid_o, rsp_result_o, rsp_err_o});
        else pass_cnt++;
        rsp_ready_i = 2'b01;
        @(negedge clk);
        rsp_ready_i = 2'b00;
    endtask

    task automatic test_tie();
        logic [1:0] exp_gnt [4];
`ifdef COMP_ARB_RR_EN
        exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req0_rs1_i = 32'h1; req0_rs2_i = 32'h1; req0_funct3_i = 3'b000;
        req1_rs1_i = 32'h0; req1_rs2_i = 32'h1; req1_funct3_i = 3'b010;
        req_valid_i = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            total_cnt++;
            if (req_ready_o !== exp_gnt[k])
                $display("FAIL tie_grant%0d: got %b want %b", k, req_ready_o, exp_gnt[k]);
            else pass_cnt++;
            @(negedge clk);
            @(negedge clk);
            total_cnt++;
            if (rsp_valid_o !== exp_gnt[k] || rsp_result_o !== 1'b1)
                $display("FAIL tie_rsp%0d: got %b/%b want %b/1", k, rsp_valid_o, rsp_result_o, exp_gnt[k]);
            else pass_cnt++;
            rsp_ready_i = 2'b11;
            @(negedge clk);
            rsp_ready_i = 2'b00;
        end
        req_valid_i = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_err_hold();
        bit acc;
        issue(0, 32'h7, 32'h7, 3'b011, acc);
        req_valid_i[1] = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (!acc || {rsp_valid_o, rsp_result_o, rsp_err_o} !== 4'b0101)
            $display("FAIL err_rsp: acc %0d got %b want 0101", acc, {rsp_valid_o, rsp_result_o, rsp_err_o});
        else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total_cnt++;
            if ({rsp_valid_o, rsp_result_o, rsp_err_o, req_ready_o} !== 6'b010100)
                $display("FAIL err_hold%0d: got %b want 010100", k, {rsp_valid_o, rsp_result_o, rsp_err_o, req_ready_o});
            else pass_cnt++;
        end
        rsp_ready_i = 2'b01;
        @(negedge clk);
        rsp_ready_i = 2'b00;
        #1;
        total_cnt++;
        if (req_ready_o !== 2'b10) $display("FAIL err_next_ready: got %b want 10", req_ready_o);
        else pass_cnt++;
        req_valid_i = 2'b00;
        @(negedge clk);
        total_cnt++;
        if (busy_o !== 1'b0) $display("FAIL withdraw_idle: busy %b want 0", busy_o);
        else pass_cnt++;
    endtask

    task automatic test_wrong_ready();
        bit acc;
        issue(0, 32'h3, 32'h4, 3'b100, acc);
        @(negedge clk);
        rsp_ready_i = 2'b10;
        @(negedge clk);
        total_cnt++;
        if (!acc || busy_o !== 1'b1 || {rsp_valid_o, rsp_result_o} !== 3'b011)
            $display("FAIL wrong_ready_hold: acc %0d busy %b got %b want 1 011", acc, busy_o, {rsp_valid_o, rsp_result_o});
        else pass_cnt++;
        rsp_ready_i = 2'b01;
        @(negedge clk);
        rsp_ready_i = 2'b00;
        total_cnt++;
        if (busy_o !== 1'b0 || rsp_valid_o !== 2'b00)
            $display("FAIL owner_ready_done: busy %b rsp_v %b want 0 00", busy_o, rsp_valid_o);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_reset_mid_eval();
        test_beq();
        test_slt_bltu();
        test_tie();
        test_err_hold();
        test_wrong_ready();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
